ssd_scan_ctrl: RTL

Time-multiplexed scan controller for the board's 4-digit common-anode seven-segment display. It owns the shared segment bus and time-slices it across the four digit anodes. It decodes a 16-bit hex value, one nibble per digit, with optional leading-zero blanking and per-digit decimal points. A pending/display double buffer lets producers (switch logic, counters) update the value at any time without tearing a frame.

---
 rtl/ssd_scan_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ssd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ssd_scan_ctrl
//
// Scan controller for a 4-digit common-anode seven-segment display. The four
// digits share one segment bus, so the controller lights one digit at a time.
// Each digit slot lasts CLK_DIV cycles. The first BLANK_CYC cycles of a slot
// keep every anode off, so the previous digit's segments do not ghost.
//
// A 16-bit hex value is shown one nibble per digit (digit 0 is rightmost).
// Leading-zero blanking and per-digit decimal points are optional.
//
// Values loaded while scanning wait in a pending register and move to the
// display register only at the end of a frame, so a frame never mixes two
// values. Values loaded while idle go straight to the display register.
//
// Parameters
//   CLK_DIV    clk cycles per digit slot (>= 2)
//   BLANK_CYC  all-anodes-off cycles at the start of each slot (< CLK_DIV)
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   enable_i      1 = scan, 0 = dark display with the scan halted
//   value_i       hex value; nibble k is shown on digit k
//   load_i        one-cycle strobe that captures value_i
//   dp_en_i       decimal-point enable per digit
//   blank_lz_i    leading-zero blanking enable
//   anode_o       active-low digit enables (registered)
//   seg_o         active-low segments {g,f,e,d,c,b,a} (registered)
//   dp_o          active-low decimal point (registered)
//   digit_sel_o   index of the current digit slot (registered)
//   frame_done_o  one-cycle pulse at the end of each digit-3 slot (registered)
// ---------------------------------------------------------------------------
module ssd_scan_ctrl #(
    parameter int CLK_DIV   = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic [15:0] value_i,
    input  logic        load_i,
    input  logic [3:0]  dp_en_i,
    input  logic        blank_lz_i,
    output logic [3:0]  anode_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [1:0]  digit_sel_o,
    output logic        frame_done_o
);

    localparam int            CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYC);

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_to_seg = 7'b1000000;
            4'h1:    hex_to_seg = 7'b1111001;
            4'h2:    hex_to_seg = 7'b0100100;
            4'h3:    hex_to_seg = 7'b0110000;
            4'h4:    hex_to_seg = 7'b0011001;
            4'h5:    hex_to_seg = 7'b0010010;
            4'h6:    hex_to_seg = 7'b0000010;
            4'h7:    hex_to_seg = 7'b1111000;
            4'h8:    hex_to_seg = 7'b0000000;
            4'h9:    hex_to_seg = 7'b0010000;
            4'hA:    hex_to_seg = 7'b0001000;
            4'hB:    hex_to_seg = 7'b0000011;
            4'hC:    hex_to_seg = 7'b1000110;
            4'hD:    hex_to_seg = 7'b0100001;
            4'hE:    hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;

    logic [3:0]    anode_d;
    logic [6:0]    seg_d;
    logic          dp_d;
    logic [1:0]    digit_sel_d;
    logic          frame_done_d;

    logic          last_cnt;
    logic          frame_end;
    logic [3:0]    nibble;
    logic          blanked;
    logic          digit_on;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        cnt_d        = cnt_q;
        dig_d        = dig_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;

        last_cnt     = (cnt_q == CNT_MAX);
        frame_end    = enable_i && last_cnt && (dig_q == 2'd3);

        // Prescaler and digit index. Idle holds both at zero, so a re-enable
        // always starts a fresh slot on digit 0.
        if (!enable_i) begin
            cnt_d = '0;
            dig_d = 2'd0;
        end else if (last_cnt) begin
            cnt_d = '0;
            dig_d = dig_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        // Double buffer. The frame-end transfer is evaluated before the load,
        // so a load on the boundary cycle moves the old pending value and
        // leaves the new one pending for the next frame.
        if (frame_end && pend_vld_q) begin
            disp_d     = pend_q;
            pend_vld_d = 1'b0;
        end
        if (load_i) begin
            if (enable_i) begin
                pend_d     = value_i;
                pend_vld_d = 1'b1;
            end else begin
                disp_d     = value_i;
            end
        end

        // Leading-zero blanking: a digit is dark when it and every digit to
        // its left are zero. Digit 0 always shows.
        nibble = disp_q[{dig_q, 2'b00} +: 4];
        case (dig_q)
            2'd3:    blanked = (disp_q[15:12] == 4'h0);
            2'd2:    blanked = (disp_q[15:8]  == 8'h00);
            2'd1:    blanked = (disp_q[15:4]  == 12'h000);
            default: blanked = 1'b0;
        endcase
        blanked  = blanked && blank_lz_i;
        digit_on = enable_i && (cnt_q >= BLANK_CNT) && !blanked;

        // Segments and dp are parked off whenever no anode is on, so the
        // shared bus is quiet during the ghost-suppression window.
        anode_d      = digit_on ? ~(4'b0001 << dig_q) : 4'b1111;
        seg_d        = digit_on ? hex_to_seg(nibble) : 7'h7F;
        dp_d         = digit_on ? ~dp_en_i[dig_q] : 1'b1;
        digit_sel_d  = enable_i ? dig_q : 2'd0;
        frame_done_d = frame_end;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            dig_q        <= 2'd0;
            disp_q       <= 16'h0000;
            pend_q       <= 16'h0000;
            pend_vld_q   <= 1'b0;
            anode_o      <= 4'b1111;
            seg_o        <= 7'h7F;
            dp_o         <= 1'b1;
            digit_sel_o  <= 2'd0;
            frame_done_o <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dig_q        <= dig_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            anode_o      <= anode_d;
            seg_o        <= seg_d;
            dp_o         <= dp_d;
            digit_sel_o  <= digit_sel_d;
            frame_done_o <= frame_done_d;
        end
    end

endmodule
